// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//   Bimodal branch predictor. A table of 2-bit saturating counters, indexed by
//   PC word address bits, supplies a combinational taken/not-taken prediction
//   for the instruction being fetched. A branch in ID/EX is captured, and it
//   resolves in the following cycle. In that cycle the comparator's
//   mispredict verdict is known. On resolve, the counter for that branch is
//   trained. A mispredict raises a one-cycle flush request on the next cycle.
//   Saturating statistics count resolved branches and mispredictions.
//
// Ports
//   clk, rst                        clock, asynchronous active-high reset
//   if_pc, if_ir                    fetch PC / instruction
//   if_branch_decision              prediction for if_ir (combinational)
//   idex_pc, idex_ir                PC / instruction currently in ID/EX
//   idex_branch_decision            prediction that travelled with idex_ir
//   idex_stall                      ID/EX holding; nothing captured this cycle
//   branch_decision_incorrect_flag  comparator verdict for the captured branch
//   mispredict_flush                one-cycle flush request
//   branch_count, mispredict_count  saturating statistics
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
  parameter int RISC_V_DATA_WIDTH = 32,
  parameter int INST_WIDTH        = 32,
  parameter int BHT_IDX_BITS      = 6,
  parameter int STAT_WIDTH        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RISC_V_DATA_WIDTH-1:0] if_pc,
  input  logic [INST_WIDTH-1:0]        if_ir,
  output logic                         if_branch_decision,
  input  logic [RISC_V_DATA_WIDTH-1:0] idex_pc,
  input  logic [INST_WIDTH-1:0]        idex_ir,
  input  logic                         idex_branch_decision,
  input  logic                         idex_stall,
  input  logic                         branch_decision_incorrect_flag,
  output logic                         mispredict_flush,
  output logic [STAT_WIDTH-1:0]        branch_count,
  output logic [STAT_WIDTH-1:0]        mispredict_count
);

  localparam int         BHT_ENTRIES = 1 << BHT_IDX_BITS;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [STAT_WIDTH-1:0] STAT_MAX = '1;

  logic [BHT_ENTRIES-1:0][1:0] bht_q;

  logic [BHT_IDX_BITS-1:0] if_idx;
  logic [BHT_IDX_BITS-1:0] idex_idx;
  logic                    if_is_branch;
  logic                    idex_is_branch;

  logic                    res_valid_reg;
  logic [BHT_IDX_BITS-1:0] res_idx_reg;
  logic                    res_pred_reg;
  logic                    mispredict_flush_reg;
  logic [STAT_WIDTH-1:0]   branch_count_reg;
  logic [STAT_WIDTH-1:0]   mispredict_count_reg;

  logic                    actual_taken;
  logic [1:0]              ctr_cur;
  logic [1:0]              ctr_next;

  assign if_idx         = if_pc[BHT_IDX_BITS+1:2];
  assign idex_idx       = idex_pc[BHT_IDX_BITS+1:2];
  assign if_is_branch   = (if_ir[6:0] == OPC_BRANCH);
  assign idex_is_branch = (idex_ir[6:0] == OPC_BRANCH);

  // Reads the current table contents: a same-cycle update of this entry is
  // not forwarded, so the prediction reflects the pre-update counter.
  assign if_branch_decision = if_is_branch & bht_q[if_idx][1];

  // The actual outcome is recovered from the prediction and the verdict.
  assign actual_taken = res_pred_reg ^ branch_decision_incorrect_flag;
  assign ctr_cur      = bht_q[res_idx_reg];

  always_comb begin
    ctr_next = ctr_cur;
    if (actual_taken) begin
      if (ctr_cur != 2'b11) ctr_next = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != 2'b00) ctr_next = ctr_cur - 2'd1;
    end
  end

  // Counters live in flops (not RAM) so reset can restore every entry at once.
  genvar gi;
  generate
    for (gi = 0; gi < BHT_ENTRIES; gi++) begin : g_bht
      logic [1:0] ctr_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          ctr_reg <= 2'b01;
        end else if (res_valid_reg && (res_idx_reg == BHT_IDX_BITS'(gi))) begin
          ctr_reg <= ctr_next;
        end
      end
      assign bht_q[gi] = ctr_reg;
    end
  endgenerate

  // Capture / resolve pipeline and statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_reg        <= 1'b0;
      res_idx_reg          <= '0;
      res_pred_reg         <= 1'b0;
      mispredict_flush_reg <= 1'b0;
      branch_count_reg     <= '0;
      mispredict_count_reg <= '0;
    end else begin
      if (idex_stall) begin
        res_valid_reg <= 1'b0;
      end else begin
        res_valid_reg <= idex_is_branch;
        res_idx_reg   <= idex_idx;
        res_pred_reg  <= idex_branch_decision;
      end

      // The verdict is sticky, so it only means something while resolving.
      mispredict_flush_reg <= res_valid_reg & branch_decision_incorrect_flag;

      if (res_valid_reg) begin
        if (branch_count_reg != STAT_MAX)
          branch_count_reg <= branch_count_reg + STAT_WIDTH'(1);
        if (branch_decision_incorrect_flag && (mispredict_count_reg != STAT_MAX))
          mispredict_count_reg <= mispredict_count_reg + STAT_WIDTH'(1);
      end
    end
  end

  assign mispredict_flush = mispredict_flush_reg;
  assign branch_count     = branch_count_reg;
  assign mispredict_count = mispredict_count_reg;

  // Only the opcode and the index bits of PC / instruction are used.
  logic unused_bits;
  assign unused_bits = ^{if_ir[INST_WIDTH-1:7], idex_ir[INST_WIDTH-1:7],
                         if_pc[RISC_V_DATA_WIDTH-1:BHT_IDX_BITS+2], if_pc[1:0],
                         idex_pc[RISC_V_DATA_WIDTH-1:BHT_IDX_BITS+2], idex_pc[1:0]};

endmodule

// File: tb/tb_branch_predictor_bht.sv
module tb_branch_predictor_bht;

  localparam int SW   = 4;          // small statistics width so saturation is reachable
  localparam int SMAX = (1 << SW) - 1;
  localparam logic [31:0] BEQ = 32'h0000_0063;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [31:0]   if_pc = '0, if_ir = NOP, idex_pc = '0, idex_ir = NOP;
  logic          idex_branch_decision = 1'b0, idex_stall = 1'b0;
  logic          branch_decision_incorrect_flag = 1'b0;
  logic          if_branch_decision, mispredict_flush;
  logic [SW-1:0] branch_count, mispredict_count;

  branch_predictor_bht #(
    .RISC_V_DATA_WIDTH(32), .INST_WIDTH(32), .BHT_IDX_BITS(6), .STAT_WIDTH(SW)
  ) dut (
    .clk(clk), .rst(rst),
    .if_pc(if_pc), .if_ir(if_ir), .if_branch_decision(if_branch_decision),
    .idex_pc(idex_pc), .idex_ir(idex_ir), .idex_branch_decision(idex_branch_decision),
    .idex_stall(idex_stall), .branch_decision_incorrect_flag(branch_decision_incorrect_flag),
    .mispredict_flush(mispredict_flush), .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int idx; bit pred; } pend_t;
  int    m_ctr[64];
  int    m_bc, m_mc;
  bit    m_flush;
  pend_t pend_q[$];

  function automatic bit is_br(logic [31:0] ir);
    return ir[6:0] == 7'b1100011;
  endfunction

  function automatic int pc_idx(logic [31:0] pc);
    return int'((pc >> 2) % 64);
  endfunction

  function automatic bit m_predict(logic [31:0] pc, logic [31:0] ir);
    return is_br(ir) && (m_ctr[pc_idx(pc)] >= 2);
  endfunction

  task automatic model_reset();
    foreach (m_ctr[i]) m_ctr[i] = 1;
    m_bc = 0; m_mc = 0; m_flush = 0;
    pend_q.delete();
  endtask

  // Applies what happens at the coming rising edge given the current inputs.
  task automatic model_edge();
    pend_t p;
    bit    actual;
    bit    nf = 0;
    if (pend_q.size() > 0) begin
      p = pend_q.pop_front();
      actual = p.pred ^ branch_decision_incorrect_flag;
      if (actual) m_ctr[p.idx] = (m_ctr[p.idx] == 3) ? 3 : m_ctr[p.idx] + 1;
      else        m_ctr[p.idx] = (m_ctr[p.idx] == 0) ? 0 : m_ctr[p.idx] - 1;
      m_bc = (m_bc == SMAX) ? SMAX : m_bc + 1;
      if (branch_decision_incorrect_flag) begin
        m_mc = (m_mc == SMAX) ? SMAX : m_mc + 1;
        nf = 1;
      end
    end
    m_flush = nf;
    if (!idex_stall && is_br(idex_ir)) pend_q.push_back('{pc_idx(idex_pc), idex_branch_decision});
  endtask

  task automatic tick();
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic check_model(input string tag);
    check({tag, " pred"},  int'(if_branch_decision), int'(m_predict(if_pc, if_ir)));
    check({tag, " flush"}, int'(mispredict_flush), int'(m_flush));
    check({tag, " bcount"}, int'(branch_count), m_bc);
    check({tag, " mcount"}, int'(mispredict_count), m_mc);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic [31:0] if_pc, if_ir, idex_pc, idex_ir;
    logic        idex_pred, stall, flag;
    logic        exp_pred, exp_flush;
    int          exp_bc, exp_mc;
  } vec_t;

  function automatic vec_t mk(logic [31:0] ipc, logic [31:0] iir, logic [31:0] dpc,
                              logic [31:0] dir, logic dp, logic st, logic fl,
                              logic ep, logic ef, int bc, int mc);
    vec_t v;
    v.if_pc = ipc; v.if_ir = iir; v.idex_pc = dpc; v.idex_ir = dir;
    v.idex_pred = dp; v.stall = st; v.flag = fl;
    v.exp_pred = ep; v.exp_flush = ef; v.exp_bc = bc; v.exp_mc = mc;
    return v;
  endfunction

  task automatic apply(input vec_t v, input string tag, input bit do_tick);
    if_pc = v.if_pc; if_ir = v.if_ir; idex_pc = v.idex_pc; idex_ir = v.idex_ir;
    idex_branch_decision = v.idex_pred; idex_stall = v.stall;
    branch_decision_incorrect_flag = v.flag;
    #1;
    check({tag, " pred"},   int'(if_branch_decision), int'(v.exp_pred));
    check({tag, " flush"},  int'(mispredict_flush), int'(v.exp_flush));
    check({tag, " bcount"}, int'(branch_count), v.exp_bc);
    check({tag, " mcount"}, int'(mispredict_count), v.exp_mc);
    if (do_tick) tick();
  endtask

  vec_t t1[4];
  vec_t seq[13];

  initial begin
    // Reset predictions: branches and non-branches all predict not-taken.
    t1[0] = mk(32'h40, BEQ, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
    t1[1] = mk(32'h40, NOP, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
    t1[2] = mk(32'h1234_5678, 32'hFFFF_FF80, 0, NOP, 0, 0, 0, 0, 0, 0, 0);
    t1[3] = mk(32'hFC, BEQ, 0, NOP, 0, 0, 0, 0, 0, 0, 0);

    // Training, saturation, mispredict flush, stall and sticky-flag rows.
    seq[0]  = mk(32'h40, BEQ, 32'h40, BEQ, 0, 0, 0, 0, 0, 0, 0);
    seq[1]  = mk(32'h40, BEQ, 32'h40, BEQ, 0, 0, 1, 0, 0, 0, 0);
    seq[2]  = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 1, 1, 1, 1, 1);
    seq[3]  = mk(32'h40, BEQ, 32'h40, BEQ, 1, 0, 0, 1, 1, 2, 2);
    seq[4]  = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 0, 1, 0, 2, 2);
    seq[5]  = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 1, 1, 0, 3, 2);
    seq[6]  = mk(32'h40, BEQ, 32'h40, BEQ, 1, 0, 1, 1, 0, 3, 2);
    seq[7]  = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 1, 1, 0, 3, 2);
    seq[8]  = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 0, 1, 1, 4, 3);
    seq[9]  = mk(32'h40, BEQ, 32'h40, BEQ, 1, 1, 1, 1, 0, 4, 3);
    seq[10] = mk(32'h40, BEQ, 32'h40, BEQ, 1, 1, 0, 1, 0, 4, 3);
    seq[11] = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 1, 1, 0, 4, 3);
    seq[12] = mk(32'h40, BEQ, 32'h00, NOP, 0, 0, 0, 1, 0, 4, 3);

    do_reset();
    for (int i = 0; i < 4; i++) apply(t1[i], $sformatf("reset_pred[%0d]", i), 1'b0);
    for (int i = 0; i < 13; i++) apply(seq[i], $sformatf("seq[%0d]", i), 1'b1);

    // Reset asserted during the resolve cycle of a mispredict.
    if_pc = 32'h40; if_ir = BEQ;
    idex_pc = 32'h40; idex_ir = BEQ; idex_branch_decision = 0; idex_stall = 0;
    branch_decision_incorrect_flag = 0;
    tick();
    idex_ir = NOP; branch_decision_incorrect_flag = 1;
    #1;
    check("pre_rst trained pred", int'(if_branch_decision), 1);
    #1;
    rst = 1'b1;
    #1;
    check("async_rst pred", int'(if_branch_decision), 0);
    check("async_rst bcount", int'(branch_count), 0);
    tick();
    rst = 1'b0;
    check("post_rst flush", int'(mispredict_flush), 0);
    check("post_rst bcount", int'(branch_count), 0);
    check("post_rst mcount", int'(mispredict_count), 0);
    branch_decision_incorrect_flag = 0;
    for (int i = 0; i < 64; i++) begin
      if_pc = 32'(i) << 2;
      #1;
      check($sformatf("post_rst pred idx%0d", i), int'(if_branch_decision), 0);
    end

    // Same-cycle predict read and update of index 5 (01 -> 10), no bypass.
    if_pc = 32'h14; if_ir = NOP;
    idex_pc = 32'h14; idex_ir = BEQ; idex_branch_decision = 0;
    tick();
    idex_ir = NOP; branch_decision_incorrect_flag = 1; if_ir = BEQ;
    #1;
    check("same_cycle pred old", int'(if_branch_decision), 0);
    tick();
    branch_decision_incorrect_flag = 0;
    #1;
    check("same_cycle pred new", int'(if_branch_decision), 1);
    check("same_cycle flush", int'(mispredict_flush), 1);

    // Back-to-back mispredicts up to and beyond statistic saturation.
    do_reset();
    idex_pc = 32'h80; idex_ir = BEQ; idex_branch_decision = 0;
    branch_decision_incorrect_flag = 1; if_pc = 32'h80; if_ir = BEQ;
    tick();
    for (int i = 0; i < 20; i++) begin
      tick();
      check($sformatf("b2b flush[%0d]", i), int'(mispredict_flush), 1);
      check($sformatf("b2b model[%0d] bcount", i), int'(branch_count), m_bc);
    end
    check("sat bcount", int'(branch_count), SMAX);
    check("sat mcount", int'(mispredict_count), SMAX);

    // Randomized run against the reference model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if_pc   = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      idex_pc = ($urandom & 32'hFFFF_FF00) | (32'($urandom_range(0, 7)) << 2) | ($urandom & 32'h3);
      if_ir   = ($urandom_range(0, 1) == 1) ? (($urandom & 32'hFFFF_FF80) | 32'h63) : $urandom;
      idex_ir = ($urandom_range(0, 2) != 0) ? (($urandom & 32'hFFFF_FF80) | 32'h63) : $urandom;
      idex_branch_decision = 1'($urandom);
      idex_stall = ($urandom_range(0, 4) == 0);
      branch_decision_incorrect_flag = ($urandom_range(0, 2) == 0);
      if (c == 1500) begin
        // Refresh statistics partway so the unsaturated range is exercised again.
        rst = 1'b1;
        model_reset();
        #1;
        rst = 1'b0;
      end
      #1;
      check_model($sformatf("rand[%0d]", c));
      tick();
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
